// File: rtl/inv_shift_rows.sv
// AES InvShiftRows byte permutation with valid/ready handshake.
// Optional forward ShiftRows select via INV_SHIFT_ROWS_FWD_EN.
module inv_shift_rows #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
`ifdef INV_SHIFT_ROWS_FWD_EN
  input  logic         i_fwd,
`endif
  input  logic [127:0] i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state
);

  // Byte k lives at [127-8k -: 8]; row = k%4, col = k/4.
  function automatic logic [127:0] shift_rows(
    input logic [127:0] s,
    input logic         fwd
  );
    logic [127:0] o;
    logic [1:0]   src_c;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (fwd) src_c = 2'(c + r);
        else     src_c = 2'(c - r);
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*int'(src_c)) -: 8];
      end
    end
    return o;
  endfunction

  logic         fwd_sel;
  logic [127:0] xf_state;

`ifdef INV_SHIFT_ROWS_FWD_EN
  assign fwd_sel = i_fwd;
`else
  assign fwd_sel = 1'b0;
`endif

  assign xf_state = shift_rows(i_state, fwd_sel);

  generate
    if (REG_OUT) begin : g_reg
      logic         vld_q;
      logic [127:0] st_q;
      logic         accept;

      assign o_ready = !vld_q || i_ready;
      assign accept  = i_valid && o_ready;

      // Single-entry output slot: load on accept, clear on drain.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          vld_q <= 1'b0;
          st_q  <= '0;
        end else if (accept) begin
          vld_q <= 1'b1;
          st_q  <= xf_state;
        end else if (i_ready && vld_q) begin
          vld_q <= 1'b0;
        end
      end

      assign o_valid = vld_q;
      assign o_state = st_q;
    end else begin : g_comb
      assign o_ready = i_ready;
      assign o_valid = i_valid;
      assign o_state = xf_state;
    end
  endgenerate

endmodule

// File: tb/tb_inv_shift_rows.sv
// Self-checking bench for inv_shift_rows.
// Vector table, back-pressure, reset and random scoreboard.
module tb_inv_shift_rows;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         i_ready;
  logic [127:0] i_state;
  logic         o_ready, o_valid;
  logic [127:0] o_state;
  logic         c_ready, c_valid;
  logic [127:0] c_state;
`ifdef INV_SHIFT_ROWS_FWD_EN
  logic         i_fwd;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] VA = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [127:0] RA = 128'h5411f4b56bd9700e96a0902fa1bb9aa1;
  localparam logic [127:0] VB = 128'h3e1c22c0b6fcbf768da85067f6170495;
  localparam logic [127:0] RB = 128'h3e175076b61c04678dfc2295f6a8bfc0;

  inv_shift_rows #(.REG_OUT(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
`ifdef INV_SHIFT_ROWS_FWD_EN
    .i_fwd(i_fwd),
`endif
    .i_state(i_state), .o_valid(o_valid),
    .i_ready(i_ready), .o_state(o_state)
  );

  inv_shift_rows #(.REG_OUT(1'b0)) u_comb (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(c_ready),
`ifdef INV_SHIFT_ROWS_FWD_EN
    .i_fwd(i_fwd),
`endif
    .i_state(i_state), .o_valid(c_valid),
    .i_ready(i_ready), .o_state(c_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: build a 4x4 matrix, rotate each row with a queue.
  function automatic logic [127:0] ref_xf(
    input logic [127:0] s, input bit fwd
  );
    logic [7:0] m [4][4];
    logic [7:0] q [$];
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      m[k % 4][k / 4] = s[127-8*k -: 8];
    for (int r = 0; r < 4; r++) begin
      q = {};
      for (int c = 0; c < 4; c++) q.push_back(m[r][c]);
      for (int n = 0; n < r; n++) begin
        if (fwd) q.push_back(q.pop_front());
        else     q.push_front(q.pop_back());
      end
      for (int c = 0; c < 4; c++) m[r][c] = q[c];
    end
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = m[k % 4][k / 4];
    return o;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] in;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];
  logic [127:0] sb [$];
  logic [127:0] exp_front;

  initial begin
    vecs[0] = '{VA, RA};
    vecs[1] = '{VB, RB};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h000d0a0704010e0b08050f0c09060300 ^
                128'h00000000000000000000020f0c090603 ^
                128'h00000000000000000000020f0c090603};
    vecs[3] = '{128'hffffffffffffffffffffffffffffffff,
                128'hffffffffffffffffffffffffffffffff};
    vecs[2].exp = 128'h000d0a0704010e0b0805020f0c090603;

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_state = '0;
`ifdef INV_SHIFT_ROWS_FWD_EN
    i_fwd   = 1'b0;
`endif
    #12;
    chk("reset_valid", 128'(o_valid), 128'd0);
    chk("reset_state", o_state, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 128'(o_ready), 128'd1);

    // Table: one cycle latency for registered, zero for comb.
    foreach (vecs[i]) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_ready = 1'b1;
      i_state = vecs[i].in;
      #1;
      chk($sformatf("comb_state_%0d", i), c_state, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("vec_valid_%0d", i), 128'(o_valid), 128'd1);
      chk($sformatf("vec_state_%0d", i), o_state, vecs[i].exp);
    end
    chk("comb_valid", 128'(c_valid), 128'd1);
    chk("comb_ready", 128'(c_ready), 128'd1);

    // Back-pressure: A held while B waits.
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    chk("drained", 128'(o_valid), 128'd0);
    i_valid = 1'b1;
    i_ready = 1'b0;
    i_state = VA;
    @(negedge clk);
    chk("bp_a_state", o_state, RA);
    i_state = VB;
    #1;
    chk("bp_ready_low", 128'(o_ready), 128'd0);
    @(negedge clk);
    chk("bp_hold_state", o_state, RA);
    chk("bp_hold_valid", 128'(o_valid), 128'd1);
    i_ready = 1'b1;
    #1;
    chk("bp_ready_up", 128'(o_ready), 128'd1);
    @(negedge clk);
    chk("bp_b_state", o_state, RB);
    chk("bp_b_valid", 128'(o_valid), 128'd1);
    i_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", 128'(o_valid), 128'd0);
    chk("bp_state_kept", o_state, RB);

    // Streaming A then B on consecutive cycles.
    i_valid = 1'b1;
    i_state = VA;
    @(negedge clk);
    chk("stream_a", o_state, RA);
    i_state = VB;
    @(negedge clk);
    chk("stream_b", o_state, RB);
    i_valid = 1'b0;

`ifdef INV_SHIFT_ROWS_FWD_EN
    @(negedge clk);
    i_fwd   = 1'b1;
    i_valid = 1'b1;
    i_state = RA;
    @(negedge clk);
    chk("fwd_state", o_state, VA);
    i_fwd   = 1'b0;
    i_valid = 1'b0;
`endif

    // Random traffic against a transaction scoreboard.
    @(negedge clk);
    sb = {};
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      i_valid = 1'($urandom_range(0, 3) != 0);
      i_ready = 1'($urandom_range(0, 2) != 0);
      i_state = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("rnd_ready", 128'(o_ready), 128'(!o_valid || i_ready));
      chk("rnd_comb", c_state, ref_xf(i_state, 1'b0));
      if (o_valid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious: o_valid with no pending item");
        end else begin
          exp_front = sb[0];
          chk("rnd_state", o_state, exp_front);
          if (i_ready) void'(sb.pop_front());
        end
      end else begin
        chk("rnd_lost", 128'(sb.size()), 128'd0);
      end
      if (i_valid && o_ready) sb.push_back(ref_xf(i_state, 1'b0));
    end

    // Reset mid-transfer discards the held result.
    @(negedge clk);
    i_valid = 1'b1;
    i_ready = 1'b0;
    i_state = VB;
    @(negedge clk);
    chk("pre_rst_valid", 128'(o_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(o_valid), 128'd0);
    chk("mid_rst_state", o_state, '0);
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 128'(o_ready), 128'd1);
    @(negedge clk);
    chk("post_rst_idle", 128'(o_valid), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
